// File: rtl/hit_manager.sv
// Purpose : turns per-pixel Pac-Man/ghost overlap into per-frame strike / ghost-eaten pulses,
//           and owns the post-hit invulnerability (with blink) and power-pellet frightened windows.
// Latency : pulses and state changes are registered, visible 1 cycle after the deciding cycle.
// Backpressure: none; all inputs are event pulses or levels and are consumed on the cycle they occur.
// Ports:
//   clk, resetN        clock, asynchronous active-low reset
//   startOfFrame       1-cycle pulse per video frame; all evaluation happens here
//   collision          level, Pac-Man overlaps a ghost pixel this cycle
//   powerPellet        1-cycle pulse, enters/reloads the frightened window
//   gameOver           1-cycle pulse from the lives bar, locks the block in DEAD
//   strike/ghostEaten  1-cycle output pulses
//   invulnerable, blinkHide, frightened, frightWarn, dead   output levels
module hit_manager #(
  parameter int INVULN_FRAMES = 120,
  parameter int FRIGHT_FRAMES = 360,
  parameter int WARN_FRAMES   = 60,
  parameter int BLINK_FRAMES  = 8,
  parameter int LIVES         = 3
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic collision,
  input  logic powerPellet,
  input  logic gameOver,
  output logic strike,
  output logic ghostEaten,
  output logic invulnerable,
  output logic blinkHide,
  output logic frightened,
  output logic frightWarn,
  output logic dead
);

  localparam int FMAX = (INVULN_FRAMES > FRIGHT_FRAMES) ? INVULN_FRAMES : FRIGHT_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);
  localparam int SW   = $clog2(LIVES + 1);
  localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [FW-1:0] INVULN_C     = FW'(INVULN_FRAMES);
  localparam logic [FW-1:0] FRIGHT_C     = FW'(FRIGHT_FRAMES);
  localparam logic [FW-1:0] WARN_C       = FW'(WARN_FRAMES);
  localparam logic [SW-1:0] LIVES_C      = SW'(LIVES);
  localparam logic [BW-1:0] BLINK_LAST_C = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {NORMAL, INVULN, FRIGHT, DEAD} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic [SW-1:0]   strike_cnt_q, strike_cnt_d;
  logic            coll_flag_q, coll_flag_d;
  logic            strike_q, strike_d;
  logic            ghost_eaten_q, ghost_eaten_d;
  logic            blink_hide_q, blink_hide_d;
  logic [FW-1:0]   frame_dec;

  // Frame counter never wraps below zero.
  assign frame_dec = (frame_cnt_q != '0) ? (frame_cnt_q - FW'(1)) : '0;

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    strike_cnt_d  = strike_cnt_q;
    blink_hide_d  = blink_hide_q;
    strike_d      = 1'b0;
    ghost_eaten_d = 1'b0;
    // On SOF the old flag is evaluated below and the flag restarts with this
    // cycle's collision, so an SOF-cycle overlap belongs to the next frame.
    coll_flag_d   = startOfFrame ? collision : (coll_flag_q | collision);

    if (state_q == DEAD) begin
      coll_flag_d  = 1'b0;
      blink_hide_d = 1'b0;
    end else if (gameOver) begin
      state_d      = DEAD;
      coll_flag_d  = 1'b0;
      blink_cnt_d  = '0;
      blink_hide_d = 1'b0;
    end else if (powerPellet) begin
      // A coincident SOF is judged as already frightened and the fresh
      // window is not decremented on this cycle.
      state_d      = FRIGHT;
      frame_cnt_d  = FRIGHT_C;
      blink_cnt_d  = '0;
      blink_hide_d = 1'b0;
      if (startOfFrame && coll_flag_q) ghost_eaten_d = 1'b1;
    end else if (startOfFrame) begin
      case (state_q)
        NORMAL: begin
          if (coll_flag_q && (strike_cnt_q < LIVES_C)) begin
            strike_d     = 1'b1;
            strike_cnt_d = strike_cnt_q + SW'(1);
            state_d      = INVULN;
            frame_cnt_d  = INVULN_C;
            blink_cnt_d  = '0;
            blink_hide_d = 1'b0;
          end
        end
        INVULN: begin
          frame_cnt_d = frame_dec;
          if (blink_cnt_q == BLINK_LAST_C) begin
            blink_cnt_d  = '0;
            blink_hide_d = ~blink_hide_q;
          end else begin
            blink_cnt_d  = blink_cnt_q + BW'(1);
          end
          // Last invulnerable frame: its collisions are dropped with the flag.
          if (frame_dec == '0) begin
            state_d      = NORMAL;
            blink_hide_d = 1'b0;
          end
        end
        FRIGHT: begin
          if (coll_flag_q) ghost_eaten_d = 1'b1;
          frame_cnt_d = frame_dec;
          if (frame_dec == '0) state_d = NORMAL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= NORMAL;
      frame_cnt_q   <= '0;
      blink_cnt_q   <= '0;
      strike_cnt_q  <= '0;
      coll_flag_q   <= 1'b0;
      strike_q      <= 1'b0;
      ghost_eaten_q <= 1'b0;
      blink_hide_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      strike_cnt_q  <= strike_cnt_d;
      coll_flag_q   <= coll_flag_d;
      strike_q      <= strike_d;
      ghost_eaten_q <= ghost_eaten_d;
      blink_hide_q  <= blink_hide_d;
    end
  end

  assign strike       = strike_q;
  assign ghostEaten   = ghost_eaten_q;
  assign invulnerable = (state_q == INVULN);
  assign blinkHide    = blink_hide_q;
  assign frightened   = (state_q == FRIGHT);
  assign frightWarn   = (state_q == FRIGHT) && (frame_cnt_q <= WARN_C);
  assign dead         = (state_q == DEAD);

endmodule

// File: doc/hit_manager.md
Name: hit_manager

Overview:
- Upstream stage of the lives bar. It turns raw, per-pixel Pac-Man/ghost collision into clean one-cycle `strike` pulses; the lives bar consumes `strike` and returns `gameOver`.
- Collisions are collapsed per frame and evaluated on `startOfFrame`.
- Also owns the post-hit invulnerability window (with Pac-Man blink) and the power-pellet frightened window (with ghost-eaten pulses).

Parameters:
- INVULN_FRAMES, 120: frames of invulnerability after a strike.
- FRIGHT_FRAMES, 360: frames of frightened mode after a power pellet.
- WARN_FRAMES, 60: final frightened frames during which `frightWarn` is high.
- BLINK_FRAMES, 8: frames per blink half-period while invulnerable.
- LIVES, 3: maximum strikes ever issued before reset.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- collision  in  1  level; Pac-Man and a ghost pixel overlap at the current pixel
- powerPellet  in  1  one-cycle pulse; power pellet eaten
- gameOver  in  1  one-cycle pulse from the lives bar
- strike  out  1  one-cycle pulse; a life is lost
- ghostEaten  out  1  one-cycle pulse; ghost eaten while frightened
- invulnerable  out  1  level; high in INVULN
- blinkHide  out  1  level; Pac-Man drawing suppressed this frame
- frightened  out  1  level; high in FRIGHT
- frightWarn  out  1  level; FRIGHT with frame counter ≤ WARN_FRAMES
- dead  out  1  level; high in DEAD

Behaviour:
- Reset: resetN (asynchronous, active-low), clock clk. On reset:
  - State = NORMAL.
  - All outputs = 0.
  - Frame counter = 0, blink counter = 0, strike counter = 0, collision flag = 0.
- Collision flag:
  - Set on any cycle with collision=1.
  - On a startOfFrame cycle the flag is first sampled for evaluation, then reloaded with that cycle's collision value. A collision on the SOF cycle therefore counts toward the next frame.
- All evaluations happen on startOfFrame cycles. Resulting output pulses are registered and appear exactly 1 cycle after that SOF cycle, lasting 1 cycle.
- States: NORMAL, INVULN, FRIGHT, DEAD.
- Priority per cycle, highest first:
  1. gameOver
  2. powerPellet
  3. SOF evaluation
- gameOver=1 in any state:
  - Next state DEAD.
  - All pulses suppressed, all levels except `dead` cleared.
  - DEAD is exited only by reset.
  - powerPellet, collision and SOF are ignored in DEAD.
- powerPellet in NORMAL, INVULN or FRIGHT:
  - Next state FRIGHT, frame counter = FRIGHT_FRAMES. In FRIGHT this reloads the window.
  - Invulnerability and blink cleared.
- If powerPellet and startOfFrame coincide:
  - The collision flag is evaluated as FRIGHT, so it yields ghostEaten, not strike.
  - The frame counter is not decremented that cycle.
- SOF in NORMAL:
  - If flag=1 and strike counter < LIVES: strike pulse; strike counter +1; state INVULN; frame counter = INVULN_FRAMES; blink counter = 0; blinkHide = 0.
  - If flag=1 and strike counter = LIVES: no pulse, stay NORMAL.
- SOF in INVULN:
  - Flag ignored.
  - Frame counter −1; blink counter +1.
  - When blink counter reaches BLINK_FRAMES−1: wrap to 0 and toggle blinkHide.
  - When frame counter reaches 0 on this SOF: state NORMAL, blinkHide = 0. Total INVULN duration is exactly INVULN_FRAMES frames.
- SOF in FRIGHT:
  - If flag=1: ghostEaten pulse. At most one per frame.
  - Frame counter −1; at 0 → NORMAL.
  - frightWarn = FRIGHT and counter ≤ WARN_FRAMES, combinational from registered state.
- Widths:
  - Frame counter: $clog2(max(INVULN_FRAMES, FRIGHT_FRAMES)+1) bits, no wrap below 0.
  - Strike counter: $clog2(LIVES+1) bits, saturating.
- strike and ghostEaten are never high in the same cycle.
- No strike is issued on the same SOF that ends INVULN. Collisions during the last INVULN frame are discarded.

Test Plan:
- Reset, then collision held for 50 cycles mid-frame, then SOF → strike=1 for exactly 1 cycle, 1 cycle after SOF; invulnerable=1; no second strike despite continued collision for 119 SOFs; invulnerable falls on the 120th SOF.
- INVULN with BLINK_FRAMES=8 → blinkHide toggles every 8 SOFs: 0 for frames 1–8, 1 for 9–16, etc.; blinkHide=0 after exit.
- powerPellet, then collision in 3 consecutive frames → 3 ghostEaten pulses, 0 strikes; frightWarn rises when the counter reaches 60; frightened falls after 360 SOFs.
- powerPellet on the same cycle as an SOF with the flag set in NORMAL → ghostEaten=1, strike=0, state FRIGHT, counter=360.
- Four separate strike sequences with LIVES=3 → exactly 3 strike pulses; the 4th collision yields none.
- gameOver pulse during FRIGHT → dead=1, frightened=0; later collision and powerPellet produce no outputs; resetN low mid-INVULN → all outputs 0 immediately (asynchronous).
